// File: rtl/pu_ram_wr_pkg.sv
// Shared definitions for the store-side port unit: size encodings, bank count
// and small helpers for byte-lane handling.
package pu_ram_wr_pkg;

  localparam int NBANK = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  // Byte k of a 32-bit store word (byte 0 in the least significant bits).
  function automatic logic [7:0] laneByte(input logic [31:0] data, input logic [1:0] k);
    return data[{k, 3'b000} +: 8];
  endfunction

  // Number of bytes moved by a size code; zero marks the reserved encoding.
  function automatic logic [2:0] sizeBytes(input size_e sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pu_ram_wr_if.sv
// Store request channel: valid/ready handshake carrying address, data and size.
interface pu_ram_wr_if;
  import pu_ram_wr_pkg::*;

  logic        valid_in;
  logic        ready_out;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  size_e       size_in;

  modport master (output valid_in, output addr_in, output data_in, output size_in,
                  input ready_out);
  modport slave  (input valid_in, input addr_in, input data_in, input size_in,
                  output ready_out);

endinterface

// File: rtl/pu_sync_fifo.sv
// Small synchronous FIFO with a separate occupancy counter so full/empty stay
// unambiguous when the power-of-two pointers wrap.
module pu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q + PW'(doPush);
    rdPtr_d = rdPtr_q + PW'(doPop);
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too, so the head-derived bank outputs read zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doPush) begin
        mem_q[wrPtr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/pu_ram_wr.sv
// Store port unit: validates and queues byte/half/word stores, then drains one
// per granted cycle across four byte-wide memory banks.
module pu_ram_wr
  import pu_ram_wr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROW_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  pu_ram_wr_if.slave       st,
  input  logic             gnt_in,
  output logic             fault_out,
  output logic             empty_out,
  output logic             we_out0,
  output logic             we_out1,
  output logic             we_out2,
  output logic             we_out3,
  output logic [ROW_W-1:0] addr_out0,
  output logic [ROW_W-1:0] addr_out1,
  output logic [ROW_W-1:0] addr_out2,
  output logic [ROW_W-1:0] addr_out3,
  output logic [7:0]       data_out0,
  output logic [7:0]       data_out1,
  output logic [7:0]       data_out2,
  output logic [7:0]       data_out3
);

  localparam int AW = ROW_W + 2;
  localparam int EW = AW + 32 + 3;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [32:0] MEM_LIMIT = 33'(1) << AW;

  logic [2:0]       nbIn;
  logic [32:0]      endAddr;
  logic             badReq;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fault_q, fault_d;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CW-1:0]    fifoCount;
  logic [EW-1:0]    wrEntry;
  logic [EW-1:0]    headEntry;
  logic [AW-1:0]    headAddr;
  logic [31:0]      headData;
  logic [2:0]       headNb;
  logic             weArr   [NBANK];
  logic [ROW_W-1:0] rowArr  [NBANK];
  logic [7:0]       byteArr [NBANK];

  // Range check runs in 33 bits so a store ending past 0xFFFFFFFF cannot wrap back in range.
  assign nbIn      = sizeBytes(st.size_in);
  assign endAddr   = {1'b0, st.addr_in} + {30'b0, nbIn} - 33'd1;
  assign badReq    = (st.size_in == SZ_RSV) || (endAddr >= MEM_LIMIT);
  assign st.ready_out = (fifoCount != CW'(DEPTH));
  assign accept    = st.valid_in && st.ready_out;
  assign push      = accept && !badReq && !fifoFull;
  assign pop       = !fifoEmpty && gnt_in;
  assign wrEntry   = {st.addr_in[AW-1:0], st.data_in, nbIn};
  assign fault_d   = accept && badReq;
  assign fault_out = fault_q;
  assign empty_out = fifoEmpty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  pu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wrEntry),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign headAddr = headEntry[EW-1 -: AW];
  assign headData = headEntry[34:3];
  assign headNb   = headEntry[2:0];

  // Bank b carries byte k of the store; banks below the start offset land on the next row.
  for (genvar b = 0; b < NBANK; b++) begin : g_lane
    logic [1:0]    k;
    logic [AW-1:0] byteAddr;

    assign k          = 2'(b) - headAddr[1:0];
    assign byteAddr   = headAddr + AW'(k);
    assign rowArr[b]  = byteAddr[AW-1:2];
    assign byteArr[b] = laneByte(headData, k);
    assign weArr[b]   = pop && ({1'b0, k} < headNb);
  end

  assign we_out0   = weArr[0];
  assign we_out1   = weArr[1];
  assign we_out2   = weArr[2];
  assign we_out3   = weArr[3];
  assign addr_out0 = rowArr[0];
  assign addr_out1 = rowArr[1];
  assign addr_out2 = rowArr[2];
  assign addr_out3 = rowArr[3];
  assign data_out0 = byteArr[0];
  assign data_out1 = byteArr[1];
  assign data_out2 = byteArr[2];
  assign data_out3 = byteArr[3];

endmodule

// File: tb/tb_pu_ram_wr.sv
// Self-checking bench for pu_ram_wr: directed scenarios plus random traffic
// checked against a byte-level queue model of the store path.
module tb_pu_ram_wr;
  import pu_ram_wr_pkg::*;

  localparam int DEPTH = 4;
  localparam int ROW_W = 11;
  localparam longint MEMB = 4 << ROW_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             gnt_in = 1'b0;
  logic             fault_out, empty_out;
  logic             we_out0, we_out1, we_out2, we_out3;
  logic [ROW_W-1:0] addr_out0, addr_out1, addr_out2, addr_out3;
  logic [7:0]       data_out0, data_out1, data_out2, data_out3;

  always #5 clk = ~clk;

  pu_ram_wr_if sif ();

  pu_ram_wr #(.DEPTH(DEPTH), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .st        (sif.slave),
    .gnt_in    (gnt_in),
    .fault_out (fault_out),
    .empty_out (empty_out),
    .we_out0   (we_out0),
    .we_out1   (we_out1),
    .we_out2   (we_out2),
    .we_out3   (we_out3),
    .addr_out0 (addr_out0),
    .addr_out1 (addr_out1),
    .addr_out2 (addr_out2),
    .addr_out3 (addr_out3),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3)
  );

  logic             weObs   [4];
  logic [ROW_W-1:0] rowObs  [4];
  logic [7:0]       byteObs [4];
  assign weObs[0] = we_out0;     assign weObs[1] = we_out1;
  assign weObs[2] = we_out2;     assign weObs[3] = we_out3;
  assign rowObs[0] = addr_out0;  assign rowObs[1] = addr_out1;
  assign rowObs[2] = addr_out2;  assign rowObs[3] = addr_out3;
  assign byteObs[0] = data_out0; assign byteObs[1] = data_out1;
  assign byteObs[2] = data_out2; assign byteObs[3] = data_out3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          nb;
  } store_t;

  store_t           q[$];
  store_t           pendEntry;
  bit               expFault;
  bit               pendAcc, pendBad, pendPop;
  bit               expWe   [4];
  logic [ROW_W-1:0] expRow  [4];
  logic [7:0]       expByte [4];
  int               checks;
  int               failures;

  function automatic int bytesFor(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle of inputs and work out, byte by byte, what the banks should see.
  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input bit g);
    int nb;
    longint ba;
    sif.valid_in = v;
    sif.addr_in  = a;
    sif.data_in  = d;
    sif.size_in  = size_e'(s);
    gnt_in       = g;
    for (int b = 0; b < 4; b++) begin
      expWe[b]   = 1'b0;
      expRow[b]  = '0;
      expByte[b] = '0;
    end
    pendPop = (q.size() > 0) && g;
    if (pendPop) begin
      for (int i = 0; i < q[0].nb; i++) begin
        ba = longint'(q[0].addr) + i;
        expWe[ba % 4]   = 1'b1;
        expRow[ba % 4]  = ROW_W'(ba / 4);
        expByte[ba % 4] = 8'(q[0].data >> (8 * i));
      end
    end
    nb = bytesFor(s);
    pendAcc = v && (q.size() != DEPTH);
    pendBad = (nb == 0) || (longint'(a) + nb > MEMB);
    pendEntry.addr = a;
    pendEntry.data = d;
    pendEntry.nb   = nb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (pendPop) void'(q.pop_front());
    if (pendAcc && !pendBad) q.push_back(pendEntry);
    expFault = pendAcc && pendBad;
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    checks++;
    if ({ready_out_w(), empty_out, fault_out} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL reset_flags ready/empty/fault=%b%b%b want 110", ready_out_w(), empty_out, fault_out);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (weObs[b] !== 1'b0 || rowObs[b] !== '0 || byteObs[b] !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_bank%0d we=%b row=%h byte=%h want 0/0/0", b, weObs[b], rowObs[b], byteObs[b]);
      end
    end
    tick();
  endtask

  function automatic logic ready_out_w();
    return sif.ready_out;
  endfunction

  task automatic test_aligned_word();
    logic [7:0] wantB [4];
    wantB = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(1'b1, 32'h10, 32'hDDCCBBAA, 2'b10, 1'b1);
    checks++;
    if (weObs[0] | weObs[1] | weObs[2] | weObs[3]) begin
      failures++;
      $display("[TB] FAIL word_no_bypass we=%b%b%b%b want 0000", weObs[3], weObs[2], weObs[1], weObs[0]);
    end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (weObs[b] !== 1'b1 || rowObs[b] !== 11'd4 || byteObs[b] !== wantB[b]) begin
        failures++;
        $display("[TB] FAIL word_bank%0d we=%b row=%0d byte=%h want 1/4/%h", b, weObs[b], rowObs[b], byteObs[b], wantB[b]);
      end
    end
    tick();
  endtask

  task automatic test_misaligned();
    bit         wWe   [4];
    int         wRow  [4];
    logic [7:0] wByte [4];
    applyStimulus(1'b1, 32'h13, 32'h00002211, 2'b01, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0E, 32'h44332211, 2'b10, 1'b1);
    wWe = '{1'b1, 1'b0, 1'b0, 1'b1};
    wRow = '{5, 0, 0, 4};
    wByte = '{8'h22, 8'h00, 8'h00, 8'h11};
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (weObs[b] !== wWe[b] || (wWe[b] && (rowObs[b] !== ROW_W'(wRow[b]) || byteObs[b] !== wByte[b]))) begin
        failures++;
        $display("[TB] FAIL half13_bank%0d we=%b row=%0d byte=%h want %b/%0d/%h", b, weObs[b], rowObs[b], byteObs[b], wWe[b], wRow[b], wByte[b]);
      end
    end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    wRow = '{4, 4, 3, 3};
    wByte = '{8'h33, 8'h44, 8'h11, 8'h22};
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (weObs[b] !== 1'b1 || rowObs[b] !== ROW_W'(wRow[b]) || byteObs[b] !== wByte[b]) begin
        failures++;
        $display("[TB] FAIL word0E_bank%0d we=%b row=%0d byte=%h want 1/%0d/%h", b, weObs[b], rowObs[b], byteObs[b], wRow[b], wByte[b]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(16 * i + 4), $urandom, 2'b10, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h100, 32'hCAFEF00D, 2'b10, 1'b1);
    checks++;
    if (sif.ready_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_ready ready_out=%b want 0", sif.ready_out);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      checks++;
      if (sif.ready_out !== (q.size() != DEPTH) || empty_out !== (q.size() == 0)) begin
        failures++;
        $display("[TB] FAIL drain_flags ready=%b empty=%b want %b/%b", sif.ready_out, empty_out, q.size() != DEPTH, q.size() == 0);
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (weObs[b] !== expWe[b] || (expWe[b] && {rowObs[b], byteObs[b]} !== {expRow[b], expByte[b]})) begin
          failures++;
          $display("[TB] FAIL drain_bank%0d we=%b row=%h byte=%h want %b/%h/%h", b, weObs[b], rowObs[b], byteObs[b], expWe[b], expRow[b], expByte[b]);
        end
      end
      tick();
    end
  endtask

  task automatic test_faults();
    logic [31:0] badAddr [2];
    logic [1:0]  badSize [2];
    badAddr = '{32'h40, 32'h1FFE};
    badSize = '{2'b11, 2'b10};
    for (int t = 0; t < 2; t++) begin
      applyStimulus(1'b1, badAddr[t], 32'h12345678, badSize[t], 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      checks++;
      if (fault_out !== 1'b1 || empty_out !== 1'b1 || (weObs[0] | weObs[1] | weObs[2] | weObs[3])) begin
        failures++;
        $display("[TB] FAIL fault%0d_pulse fault=%b empty=%b we=%b%b%b%b want 1/1/0000", t, fault_out, empty_out, weObs[3], weObs[2], weObs[1], weObs[0]);
      end
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      checks++;
      if (fault_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fault%0d_one_cycle fault=%b want 0", t, fault_out);
      end
      tick();
    end
    applyStimulus(1'b1, 32'h1FFC, 32'h87654321, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    checks++;
    if (fault_out !== 1'b0 || empty_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL edge_accept fault=%b empty=%b want 0/0", fault_out, empty_out);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (weObs[b] !== 1'b1 || rowObs[b] !== 11'h7FF || byteObs[b] !== 8'(32'h87654321 >> (8 * b))) begin
        failures++;
        $display("[TB] FAIL edge_bank%0d we=%b row=%h byte=%h want 1/7ff", b, weObs[b], rowObs[b], byteObs[b]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int c = 0; c < 400; c++) begin
      case ($urandom % 8)
        0:       a = $urandom;
        1:       a = 32'($urandom_range(8180, 8200));
        default: a = 32'($urandom_range(0, 8191));
      endcase
      applyStimulus(($urandom % 4) != 0, a, $urandom, 2'($urandom % 4), ($urandom % 3) != 0);
      checks++;
      if (sif.ready_out !== (q.size() != DEPTH) || empty_out !== (q.size() == 0) || fault_out !== expFault) begin
        failures++;
        $display("[TB] FAIL rand_flags c=%0d ready=%b empty=%b fault=%b want %b/%b/%b", c, sif.ready_out, empty_out, fault_out, q.size() != DEPTH, q.size() == 0, expFault);
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (weObs[b] !== expWe[b] || (expWe[b] && {rowObs[b], byteObs[b]} !== {expRow[b], expByte[b]})) begin
          failures++;
          $display("[TB] FAIL rand_bank%0d c=%0d we=%b row=%h byte=%h want %b/%h/%h", b, c, weObs[b], rowObs[b], byteObs[b], expWe[b], expRow[b], expByte[b]);
        end
      end
      tick();
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    checks++;
    if (empty_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rand_drained empty=%b want 1", empty_out);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(8 * i + 1), $urandom, 2'b10, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    rst = 1'b0;
    #1;
    q.delete();
    expFault = 1'b0;
    checks++;
    if (empty_out !== 1'b1 || sif.ready_out !== 1'b1 || fault_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_flags empty=%b ready=%b fault=%b want 1/1/0", empty_out, sif.ready_out, fault_out);
    end
    checks++;
    if (weObs[0] | weObs[1] | weObs[2] | weObs[3]) begin
      failures++;
      $display("[TB] FAIL rst_mid_we we=%b%b%b%b want 0000", weObs[3], weObs[2], weObs[1], weObs[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      checks++;
      if ((weObs[0] | weObs[1] | weObs[2] | weObs[3]) || empty_out !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rst_after_we c=%0d we=%b%b%b%b empty=%b want 0000/1", c, weObs[3], weObs[2], weObs[1], weObs[0], empty_out);
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expFault = 1'b0;
    sif.valid_in = 1'b0;
    sif.addr_in  = '0;
    sif.data_in  = '0;
    sif.size_in  = SZ_B;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_aligned_word();
    test_misaligned();
    test_backpressure();
    test_faults();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
